packed_acc: RTL and testbench
=============================

Name: packed_acc

Overview:
- Sequential accumulator that consumes a stream of packed operands and reduces each frame to a single result.
- Supports add/subtract per beat, for differential accumulation in the diff-NN datapath.
- Two arithmetic modes: full-width, or bit_mode, which is two independent WIDTH/2 signed lanes with no inter-lane carry and no truncation logic (wrap-around).
- Sits downstream of the packed adder stage; hands frame results to the next pipeline stage over a valid/ready handshake.

Parameters:
- WIDTH, 32, data width; must be even; lanes are [WIDTH-1:WIDTH/2] (hi) and [WIDTH/2-1:0] (lo).
- CNT_W, 8, width of the per-frame beat counter.

Ports:
- clk, input, 1, clock; all logic on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, block can accept a beat.
- in_data, input, WIDTH, packed operand, two's complement.
- in_sub, input, 1, 1 = subtract this beat, 0 = add.
- in_last, input, 1, final beat of the frame.
- bit_mode, input, 1, 1 = dual-lane mode; sampled only on the first beat of a frame.
- out_valid, output, 1, frame result valid.
- out_ready, input, 1, downstream accepts the result.
- out_data, output, WIDTH, accumulated result.
- out_mode, output, 1, bit_mode latched for the frame.
- out_count, output, CNT_W, number of beats in the frame, saturating.

Behaviour:
- Beat accepted when in_valid && in_ready. Result transferred when out_valid && out_ready.
- FSM states: IDLE, ACC, HOLD. in_ready = 1 in IDLE and ACC, 0 in HOLD (decoded from state).
- IDLE, beat accepted:
  - acc <= 0 ± in_data; mode_q <= bit_mode; cnt <= 1.
  - in_last=1 -> HOLD; otherwise -> ACC.
- ACC, beat accepted:
  - acc <= acc ± in_data using mode_q; bit_mode input is ignored; cnt <= cnt+1, saturating at 2^CNT_W-1.
  - in_last=1 -> HOLD; otherwise stay in ACC.
- No accepted beat in IDLE or ACC: state and registers unchanged; idle gaps mid-frame are legal.
- HOLD:
  - out_valid=1.
  - out_data, out_mode and out_count hold stable until out_ready.
  - On out_ready -> IDLE.
  - One-cycle input bubble between frames, by design.
- Arithmetic, mode_q=0: full-width add/sub modulo 2^WIDTH.
- Arithmetic, mode_q=1:
  - Each lane computes lane_acc ± lane_in modulo 2^(WIDTH/2).
  - No carry or borrow crosses the lane boundary.
  - in_sub applies to both lanes.
- Latency: out_valid rises the cycle after the in_last beat is accepted.
- out_data/out_mode/out_count are driven from the accumulator, mode and count registers at all times; they are meaningful only while out_valid=1.
- Reset (async, any state, including mid-frame or in HOLD with an unaccepted result):
  - state=IDLE; acc, cnt, mode_q = 0.
  - out_valid=0; in_ready=1 after reset is released.
  - A partial frame is discarded with no output.
- Input values while in_valid=0 are don't-care and never affect state.

Test Plan:
1. Full mode, WIDTH=32: beats 5(add), 7(sub), 10(add, last) -> out_valid one cycle after last, out_data=8, out_count=3, out_mode=0.
2. bit_mode=1: beats 0x0001_FFFF, 0x0002_0001 (last) -> out_data=0x0003_0000; lo lane wraps, no carry into hi.
3. bit_mode=1 subtract: beats 0x0000_0000, then sub 0x0001_0001 (last) -> out_data=0xFFFF_FFFF; a full-mode rerun of the same beats gives 0xFFFE_FFFF.
4. Single-beat frame: data 0x8000_0000, in_sub=1, in_last=1, full mode -> out_data=0x8000_0000, out_count=1. Also toggle bit_mode mid-frame in a separate frame -> out_mode equals the first-beat value.
5. Backpressure: hold out_ready=0 for 3 cycles in HOLD while in_valid=1 -> out_valid stays 1, outputs stable, in_ready=0, no beat consumed. Then out_ready=1 -> IDLE next cycle; the next frame starts cleanly.
6. Reset and count saturation:
   - Assert rst_n low after 2 beats of a frame -> out_valid=0, out_data=0. A following 1-beat frame of 3 yields 3.
   - With CNT_W=8, a 300-beat frame of value 1 -> out_data=300, out_count=255.

Source files
------------

// File: rtl/packed_acc.sv
// ============================================================================
// Module      : packed_acc
// Description : Frame accumulator for packed operands. Each frame is reduced
//               either full-width or as two independent signed half-width
//               lanes, then handed downstream over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module packed_acc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sub,
    input  logic             in_last,
    input  logic             bit_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic [CNT_W-1:0] out_count
);

    localparam int             c_HALF    = WIDTH / 2;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_mode;

    logic               w_accept;
    logic               w_first;
    logic               w_mode_eff;
    logic [WIDTH-1:0]   w_base;
    logic [WIDTH-1:0]   w_full;
    logic [c_HALF-1:0]  w_lane_hi;
    logic [c_HALF-1:0]  w_lane_lo;
    logic [WIDTH-1:0]   w_acc_next;
    logic [CNT_W-1:0]   w_cnt_next;

    assign in_ready  = (r_state != HOLD);
    assign out_valid = (r_state == HOLD);
    assign out_data  = r_acc;
    assign out_mode  = r_mode;
    assign out_count = r_cnt;

    assign w_accept = in_valid && in_ready;
    assign w_first  = (r_state == IDLE);

    // First beat of a frame starts from zero and takes the live bit_mode.
    assign w_mode_eff = w_first ? bit_mode : r_mode;
    assign w_base     = w_first ? '0 : r_acc;

    assign w_full    = in_sub ? (w_base - in_data) : (w_base + in_data);
    assign w_lane_hi = in_sub ? (w_base[WIDTH-1:c_HALF] - in_data[WIDTH-1:c_HALF])
                              : (w_base[WIDTH-1:c_HALF] + in_data[WIDTH-1:c_HALF]);
    assign w_lane_lo = in_sub ? (w_base[c_HALF-1:0] - in_data[c_HALF-1:0])
                              : (w_base[c_HALF-1:0] + in_data[c_HALF-1:0]);

    assign w_acc_next = w_mode_eff ? {w_lane_hi, w_lane_lo} : w_full;
    assign w_cnt_next = w_first ? CNT_W'(1)
                      : ((r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, ACC: begin
                if (w_accept) begin
                    w_state_next = in_last ? HOLD : ACC;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_mode <= 1'b0;
        end else if (w_accept) begin
            r_acc  <= w_acc_next;
            r_cnt  <= w_cnt_next;
            r_mode <= w_mode_eff;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_packed_acc.sv
// ============================================================================
// Module      : tb_packed_acc
// Description : Directed self-checking bench for packed_acc.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_packed_acc;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sub;
    logic             in_last;
    logic             bit_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_mode;
    logic [CNT_W-1:0] out_count;

    int vectors;
    int miscompares;

    packed_acc #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .in_last   (in_last),
        .bit_mode  (bit_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called 1 time unit after a rising edge; returns at the same phase.
    task automatic drive_beat(input logic [WIDTH-1:0] d, input logic sub,
                              input logic last, input logic mode);
        in_valid = 1'b1;
        in_data  = d;
        in_sub   = sub;
        in_last  = last;
        bit_mode = mode;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sub   = 1'b0;
        in_last  = 1'b0;
        in_data  = 32'hDEAD_BEEF;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        vectors++; if (out_data !== 32'h0) begin miscompares++; $display("FAIL rst_out_data got %h exp 0", out_data); end
        vectors++; if (out_count !== 8'd0) begin miscompares++; $display("FAIL rst_out_count got %0d exp 0", out_count); end
        vectors++; if (out_mode !== 1'b0) begin miscompares++; $display("FAIL rst_out_mode got %b exp 0", out_mode); end
    endtask

    task automatic test_full_mode();
        drive_beat(32'd5, 1'b0, 1'b0, 1'b0);
        // idle gap with junk on the data bus must be ignored
        in_data = 32'h1111_1111; in_sub = 1'b1;
        @(posedge clk); #1;
        drive_beat(32'd7, 1'b1, 1'b0, 1'b0);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL full_early_valid got %b exp 0", out_valid); end
        drive_beat(32'd10, 1'b0, 1'b1, 1'b0);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL full_valid got %b exp 1", out_valid); end
        vectors++; if (out_data !== 32'd8) begin miscompares++; $display("FAIL full_data got %h exp %h", out_data, 32'd8); end
        vectors++; if (out_count !== 8'd3) begin miscompares++; $display("FAIL full_count got %0d exp 3", out_count); end
        vectors++; if (out_mode !== 1'b0) begin miscompares++; $display("FAIL full_mode got %b exp 0", out_mode); end
        release_result();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL full_release got %b exp 0", out_valid); end
    endtask

    task automatic test_bit_mode();
        drive_beat(32'h0001_FFFF, 1'b0, 1'b0, 1'b1);
        drive_beat(32'h0002_0001, 1'b0, 1'b1, 1'b1);
        vectors++; if (out_data !== 32'h0003_0000) begin miscompares++; $display("FAIL lane_add got %h exp %h", out_data, 32'h0003_0000); end
        vectors++; if (out_mode !== 1'b1) begin miscompares++; $display("FAIL lane_add_mode got %b exp 1", out_mode); end
        release_result();
    endtask

    task automatic test_bit_mode_sub();
        drive_beat(32'h0000_0000, 1'b0, 1'b0, 1'b1);
        drive_beat(32'h0001_0001, 1'b1, 1'b1, 1'b1);
        vectors++; if (out_data !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL lane_sub got %h exp %h", out_data, 32'hFFFF_FFFF); end
        release_result();
        drive_beat(32'h0000_0000, 1'b0, 1'b0, 1'b0);
        drive_beat(32'h0001_0001, 1'b1, 1'b1, 1'b0);
        vectors++; if (out_data !== 32'hFFFE_FFFF) begin miscompares++; $display("FAIL full_sub got %h exp %h", out_data, 32'hFFFE_FFFF); end
        release_result();
    endtask

    task automatic test_single_beat();
        drive_beat(32'h8000_0000, 1'b1, 1'b1, 1'b0);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b exp 1", out_valid); end
        vectors++; if (out_data !== 32'h8000_0000) begin miscompares++; $display("FAIL single_data got %h exp %h", out_data, 32'h8000_0000); end
        vectors++; if (out_count !== 8'd1) begin miscompares++; $display("FAIL single_count got %0d exp 1", out_count); end
        release_result();
        // bit_mode changes mid-frame; the lane mode of the first beat must persist
        drive_beat(32'h0000_FFFF, 1'b0, 1'b0, 1'b1);
        drive_beat(32'h0000_0001, 1'b0, 1'b1, 1'b0);
        vectors++; if (out_mode !== 1'b1) begin miscompares++; $display("FAIL latched_mode got %b exp 1", out_mode); end
        vectors++; if (out_data !== 32'h0000_0000) begin miscompares++; $display("FAIL latched_data got %h exp %h", out_data, 32'h0); end
        release_result();
    endtask

    task automatic test_backpressure();
        drive_beat(32'h0000_1234, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b1; in_data = 32'h0000_0055; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid[%0d] got %b exp 1", i, out_valid); end
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, in_ready); end
            vectors++; if (out_data !== 32'h0000_1234) begin miscompares++; $display("FAIL bp_data[%0d] got %h exp %h", i, out_data, 32'h1234); end
            vectors++; if (out_count !== 8'd1) begin miscompares++; $display("FAIL bp_count[%0d] got %0d exp 1", i, out_count); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_to_idle got %b exp 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_idle_ready got %b exp 1", in_ready); end
        drive_beat(32'd9, 1'b0, 1'b1, 1'b0);
        vectors++; if (out_data !== 32'd9) begin miscompares++; $display("FAIL bp_next_data got %h exp %h", out_data, 32'd9); end
        vectors++; if (out_count !== 8'd1) begin miscompares++; $display("FAIL bp_next_count got %0d exp 1", out_count); end
        release_result();
    endtask

    task automatic test_mid_frame_reset();
        drive_beat(32'd4, 1'b0, 1'b0, 1'b0);
        drive_beat(32'd4, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mrst_valid got %b exp 0", out_valid); end
        vectors++; if (out_data !== 32'h0) begin miscompares++; $display("FAIL mrst_data got %h exp 0", out_data); end
        vectors++; if (out_count !== 8'd0) begin miscompares++; $display("FAIL mrst_count got %0d exp 0", out_count); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mrst_ready got %b exp 1", in_ready); end
        drive_beat(32'd3, 1'b0, 1'b1, 1'b0);
        vectors++; if (out_data !== 32'd3) begin miscompares++; $display("FAIL mrst_next_data got %h exp %h", out_data, 32'd3); end
        release_result();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            drive_beat(32'd1, 1'b0, (i == 299), 1'b0);
        end
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL sat_valid got %b exp 1", out_valid); end
        vectors++; if (out_data !== 32'd300) begin miscompares++; $display("FAIL sat_data got %0d exp 300", out_data); end
        vectors++; if (out_count !== 8'd255) begin miscompares++; $display("FAIL sat_count got %0d exp 255", out_count); end
        release_result();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_sub      = 1'b0;
        in_last     = 1'b0;
        bit_mode    = 1'b0;
        out_ready   = 1'b0;
        #12;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_full_mode();
        test_bit_mode();
        test_bit_mode_sub();
        test_single_beat();
        test_backpressure();
        test_mid_frame_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

`default_nettype wire
